qtree_stream_loader: RTL and testbench

//  Parametrised host-side loader for QTree benchmarks. Deserialises N_TREES postfix-ordered

---
 rtl/qtree_stream_loader.sv | 173 +++++++++++++++++
 tb/tb_qtree_stream_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/qtree_stream_loader.sv
// Host-side QTree loader: deserialises postfix trees into the heap, then hands roots and Go to the kernel.
//   LOAD     | accept one stream beat      WRITE | heap write pending      WAIT_PTR | await allocated pointer
//   ISSUE    | present root pointers       GO    | Go token pending        RUN      | await kernel result
//   DONE     | result captured             ERROR | sticky fault, halted
module qtree_stream_loader #(
  parameter int PTR_W       = 16,
  parameter int VAL_W       = 32,
  parameter int ARITY       = 4,
  parameter int N_TREES     = 3,
  parameter int STACK_DEPTH = 256,
  parameter int RES_W       = 32
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [VAL_W+1:0]         s_tdata,
  input  logic                     s_tlast,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  output logic [2+ARITY*PTR_W-1:0] wr_data,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  input  logic [PTR_W-1:0]         ptr_data,
  input  logic                     ptr_valid,
  output logic [PTR_W-1:0]         root_ptr,
  output logic [3:0]               root_idx,
  output logic                     root_valid,
  input  logic                     root_ready,
  output logic                     go_valid,
  input  logic                     go_ready,
  input  logic [RES_W-1:0]         res_data,
  input  logic                     res_valid,
  output logic                     res_ready,
  output logic [RES_W-1:0]         result_data,
  output logic                     done,
  output logic [1:0]               err
);

  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  localparam int AW   = SP_W - 1;
  localparam int WW   = 2 + ARITY * PTR_W;

  typedef enum logic [2:0] {
    S_LOAD, S_WRITE, S_WAIT_PTR, S_ISSUE, S_GO, S_RUN, S_DONE, S_ERROR
  } state_t;

  state_t            r_state, w_next;
  logic [SP_W-1:0]   r_sp, w_sp_next, w_base;
  logic [4:0]        r_cnt;
  logic [3:0]        r_ridx;
  logic              r_tready, r_tlast;
  logic [WW-1:0]     r_wr_data, w_beat_word;
  logic [PTR_W-1:0]  r_stack [STACK_DEPTH];
  logic [PTR_W-1:0]  r_roots [16];
  logic [RES_W-1:0]  r_result;
  logic              r_done;
  logic [1:0]        r_err, w_err_next;
  logic              w_beat, w_push, w_root;
  logic [1:0]        w_tag;
  logic [VAL_W-1:0]  w_val;

  assign w_beat = s_tvalid & r_tready;
  assign w_tag  = s_tdata[1:0];
  assign w_val  = s_tdata[VAL_W+1:2];
  assign w_base = r_sp - SP_W'(ARITY);
  assign w_push = (r_state == S_WAIT_PTR) && ptr_valid && (r_sp != SP_W'(STACK_DEPTH));
  // A tree is complete only when its root is the sole entry after the push.
  assign w_root = w_push && r_tlast && (r_sp == '0);

  always_comb begin
    w_beat_word = '0;
    if (w_tag == 2'd2) begin
      w_beat_word[1:0] = 2'd2;
      for (int k = 0; k < ARITY; k++)
        w_beat_word[2+k*PTR_W +: PTR_W] = r_stack[AW'(w_base + SP_W'(k))];
    end else begin
      w_beat_word[VAL_W+1:2] = w_val;
      w_beat_word[1:0]       = w_tag;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_sp_next  = r_sp;
    w_err_next = r_err;
    case (r_state)
      S_LOAD: begin
        if (w_beat) begin
          if (w_tag == 2'd2 && r_sp < SP_W'(ARITY)) begin
            w_next     = S_ERROR;
            w_err_next = 2'd1;
          end else begin
            w_next = S_WRITE;
            if (w_tag == 2'd2) w_sp_next = w_base;
          end
        end
      end
      S_WRITE: if (wr_ready) w_next = S_WAIT_PTR;
      S_WAIT_PTR: begin
        if (ptr_valid) begin
          if (r_sp == SP_W'(STACK_DEPTH)) begin
            w_next     = S_ERROR;
            w_err_next = 2'd2;
          end else if (r_tlast) begin
            if (r_sp != '0) begin
              w_next     = S_ERROR;
              w_err_next = 2'd3;
            end else begin
              w_sp_next = '0;
              w_next    = (r_cnt == 5'(N_TREES - 1)) ? S_ISSUE : S_LOAD;
            end
          end else begin
            w_sp_next = r_sp + 1'b1;
            w_next    = S_LOAD;
          end
        end
      end
      S_ISSUE: if (root_ready && r_ridx == 4'(N_TREES - 1)) w_next = S_GO;
      S_GO:    if (go_ready) w_next = S_RUN;
      S_RUN:   if (res_valid) w_next = S_DONE;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_LOAD;
      r_sp      <= '0;
      r_cnt     <= '0;
      r_ridx    <= '0;
      r_tready  <= 1'b0;
      r_tlast   <= 1'b0;
      r_wr_data <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_err     <= 2'd0;
    end else begin
      r_state  <= w_next;
      r_sp     <= w_sp_next;
      r_err    <= w_err_next;
      r_tready <= (w_next == S_LOAD);
      if (r_state == S_LOAD && w_beat) begin
        r_tlast   <= s_tlast;
        r_wr_data <= w_beat_word;
      end
      if (w_root) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_ISSUE && root_ready && r_ridx != 4'(N_TREES - 1))
        r_ridx <= r_ridx + 1'b1;
      if (r_state == S_RUN && res_valid) begin
        r_result <= res_data;
        r_done   <= 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; sp and count gate every read.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[AW-1:0]] <= ptr_data;
    if (w_root) r_roots[r_cnt[3:0]]   <= ptr_data;
  end

  assign s_tready    = r_tready;
  assign wr_valid    = (r_state == S_WRITE);
  assign wr_data     = r_wr_data;
  assign root_valid  = (r_state == S_ISSUE);
  assign root_ptr    = r_roots[r_ridx];
  assign root_idx    = r_ridx;
  assign go_valid    = (r_state == S_GO);
  assign res_ready   = (r_state == S_RUN);
  assign result_data = r_result;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_qtree_stream_loader.sv
// Directed scoreboard bench for qtree_stream_loader (N_TREES=3, STACK_DEPTH=4).
module tb_qtree_stream_loader;

  localparam int PTR_W = 16, VAL_W = 32, ARITY = 4, NT = 3, SD = 4, RES_W = 32;
  localparam int WW = 2 + ARITY * PTR_W;

  logic             clk, aresetn;
  logic [VAL_W+1:0] s_tdata;
  logic             s_tlast, s_tvalid, s_tready;
  logic [WW-1:0]    wr_data;
  logic             wr_valid, wr_ready;
  logic [PTR_W-1:0] ptr_data, root_ptr;
  logic             ptr_valid;
  logic [3:0]       root_idx;
  logic             root_valid, root_ready, go_valid, go_ready;
  logic [RES_W-1:0] res_data, result_data;
  logic             res_valid, res_ready, done;
  logic [1:0]       err;

  qtree_stream_loader #(.PTR_W(PTR_W), .VAL_W(VAL_W), .ARITY(ARITY), .N_TREES(NT),
                        .STACK_DEPTH(SD), .RES_W(RES_W)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .ptr_data(ptr_data), .ptr_valid(ptr_valid),
    .root_ptr(root_ptr), .root_idx(root_idx), .root_valid(root_valid), .root_ready(root_ready),
    .go_valid(go_valid), .go_ready(go_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .result_data(result_data), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  logic [WW-1:0]    wq[$];
  logic [PTR_W-1:0] mstack[$];
  logic [PTR_W-1:0] rq[$];

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    n_vec++;
    n_fail++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    s_tvalid = 0; s_tlast = 0; s_tdata = '0;
    wr_ready = 1; ptr_valid = 0; ptr_data = '0;
    root_ready = 0; go_ready = 0; res_valid = 0; res_data = '0;
    tick(); tick();
    wq.delete(); mstack.delete(); rq.delete();
    aresetn = 1'b1;
    tick();
  endtask

  function automatic logic [WW-1:0] leaf_word(input logic [1:0] tag, input logic [31:0] val);
    logic [WW-1:0] w;
    w = '0;
    w[VAL_W+1:2] = val;
    w[1:0] = tag;
    return w;
  endfunction

  task automatic wait_tready();
    int t = 0;
    while (!s_tready && t < 50) begin tick(); t++; end
    if (!s_tready) tmo("tready_wait");
  endtask

  // Drives one beat; when a write is expected, services the write and returns ptr.
  task automatic send_beat(input logic [1:0] tag, input logic [31:0] val, input logic last,
                           input logic [15:0] ptr, input bit exp_write);
    logic [WW-1:0] w;
    int t;
    wait_tready();
    if (exp_write) begin
      if (tag == 2'd2) begin
        w = '0;
        w[1:0] = 2'd2;
        for (int k = 0; k < ARITY; k++)
          w[2+k*PTR_W +: PTR_W] = mstack[mstack.size() - ARITY + k];
        for (int k = 0; k < ARITY; k++) void'(mstack.pop_back());
      end else begin
        w = leaf_word(tag, val);
      end
      wq.push_back(w);
    end
    s_tdata = {val, tag}; s_tlast = last; s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (!exp_write) return;
    t = 0;
    while (!(wr_valid && wr_ready) && t < 50) begin tick(); t++; end
    if (!wr_valid) begin tmo("wr_valid_wait"); return; end
    chk("wr_data", wr_data, wq.pop_front());
    tick();
    ptr_valid = 1'b1; ptr_data = ptr;
    tick();
    ptr_valid = 1'b0;
    mstack.push_back(ptr);
    if (last) rq.push_back(mstack.pop_back());
  endtask

  task automatic run_full();
    int t;
    send_beat(2'd1, 32'd7, 1'b1, 16'h0005, 1'b1);
    for (int i = 0; i < 4; i++) send_beat(2'd1, 32'(100 + i), 1'b0, 16'(i + 1), 1'b1);
    send_beat(2'd2, 32'd0, 1'b1, 16'h0008, 1'b1);
    send_beat(2'd3, 32'hABCD, 1'b1, 16'h000C, 1'b1);
    t = 0;
    while (!root_valid && t < 50) begin tick(); t++; end
    if (!root_valid) tmo("root_valid_wait");
    root_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_root_valid", root_valid, 1);
      chk("stall_root_ptr", root_ptr, rq[0]);
      chk("stall_root_idx", root_idx, 0);
      tick();
    end
    root_ready = 1'b1;
    for (int i = 0; i < NT; i++) begin
      chk("root_valid", root_valid, 1);
      chk("root_ptr", root_ptr, rq.pop_front());
      chk("root_idx", root_idx, i);
      tick();
    end
    root_ready = 1'b0;
    chk("root_valid_after", root_valid, 0);
    chk("go_valid", go_valid, 1);
    go_ready = 1'b1;
    tick();
    go_ready = 1'b0;
    chk("go_valid_after", go_valid, 0);
    chk("res_ready_run", res_ready, 1);
    chk("done_before", done, 0);
    res_data = 32'd42; res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("done", done, 1);
    chk("result_data", result_data, 42);
    chk("res_ready_done", res_ready, 0);
    chk("tready_done", s_tready, 0);
    chk("err_clean", err, 0);
    chk("wq_empty", wq.size(), 0);
  endtask

  initial begin
    aresetn = 1'b0;
    s_tvalid = 0; s_tlast = 0; s_tdata = '0;
    wr_ready = 1; ptr_valid = 0; ptr_data = '0;
    root_ready = 0; go_ready = 0; res_valid = 0; res_data = '0;
    #3;
    chk("rst_tready", s_tready, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_root_valid", root_valid, 0);
    chk("rst_go_valid", go_valid, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result_data, 0);
    do_reset();

    run_full();

    do_reset();
    send_beat(2'd1, 32'd1, 1'b0, 16'h0001, 1'b1);
    send_beat(2'd1, 32'd2, 1'b0, 16'h0002, 1'b1);
    send_beat(2'd2, 32'd0, 1'b1, 16'h0003, 1'b0);
    chk("underflow_wr_valid", wr_valid, 0);
    chk("underflow_err", err, 1);
    tick(); tick(); tick();
    chk("underflow_tready", s_tready, 0);
    chk("underflow_wr_valid_late", wr_valid, 0);

    do_reset();
    send_beat(2'd1, 32'd1, 1'b0, 16'h0001, 1'b1);
    send_beat(2'd1, 32'd2, 1'b1, 16'h0002, 1'b1);
    chk("badroot_err", err, 3);
    chk("badroot_tready", s_tready, 0);

    do_reset();
    for (int i = 0; i < 4; i++) send_beat(2'd1, 32'(i), 1'b0, 16'(i + 1), 1'b1);
    chk("full_no_err", err, 0);
    send_beat(2'd1, 32'd9, 1'b0, 16'h0009, 1'b1);
    chk("overflow_err", err, 2);
    chk("overflow_tready", s_tready, 0);

    do_reset();
    wr_ready = 1'b0;
    wait_tready();
    s_tdata = {32'h55, 2'd1}; s_tlast = 1'b1; s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_wr_valid", wr_valid, 1);
      chk("stall_wr_data", wr_data, leaf_word(2'd1, 32'h55));
      tick();
    end
    #3 aresetn = 1'b0;
    #1;
    chk("async_wr_valid", wr_valid, 0);
    chk("async_tready", s_tready, 0);
    wr_ready = 1'b1;
    tick();
    wq.delete(); mstack.delete(); rq.delete();
    aresetn = 1'b1;
    tick();
    chk("restart_err", err, 0);
    run_full();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
